// File: rtl/dotmatrix_ctrl_if.sv
// dotmatrix_ctrl_if: CS/Write/Read bus with 4-phase ack between system fabric and the dot-matrix controller
interface dotmatrix_ctrl_if;
    logic       CS;
    logic       Write;
    logic       Read;
    logic [7:0] Address;
    logic [7:0] Data_i;
    logic [3:0] STRB;
    logic [7:0] Data_o;
    logic       ack;

    modport master (output CS, Write, Read, Address, Data_i, STRB, input Data_o, ack);
    modport slave  (input CS, Write, Read, Address, Data_i, STRB, output Data_o, ack);
endinterface

// File: rtl/dotmatrix_ctrl.sv
// dotmatrix_ctrl: 8x8 LED matrix frame buffer with bus slave and row scanner.
// Define DOTMATRIX_READ_EN to enable the buffer read-back path.
module dotmatrix_ctrl #(
    parameter int SCAN_DIV = 2500,
    parameter int CNT_W    = 16
) (
    input  logic                   mclock,
    input  logic                   mreset,
    dotmatrix_ctrl_if.slave        bus,
    output logic [7:0]             Row,
    output logic [7:0]             Col
);
    typedef enum logic {IDLE, ACKED} state_t;

    // Frame buffer deliberately has no reset so preloaded images survive it.
    logic [7:0] image_mem [0:7];

    state_t           r_state;
    state_t           w_next;
    logic             w_req;
    logic             w_wr;
    logic             w_rd;
    logic             w_in_range;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_idx;
    logic [7:0]       r_row;
    logic [7:0]       r_col;
    logic             w_wrap;
    logic             w_unused;

    assign w_unused   = ^bus.STRB;
    assign w_in_range = bus.Address < 8'd8;
    assign w_req      = bus.CS && (bus.Write || bus.Read);
    assign w_wr       = mreset && r_state == IDLE && bus.CS && bus.Write;
    assign w_rd       = mreset && r_state == IDLE && bus.CS && bus.Read && !bus.Write;

    always_ff @(posedge mclock or negedge mreset) begin
        if (!mreset) r_state <= IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_next = (r_state == IDLE) ? (w_req ? ACKED : IDLE) : (bus.CS ? ACKED : IDLE);
    end

    assign bus.ack = r_state == ACKED;

    always @(posedge mclock) begin
        if (w_wr && w_in_range) image_mem[bus.Address[2:0]] <= bus.Data_i;
    end

`ifdef DOTMATRIX_READ_EN
    logic [7:0] r_data;

    always_ff @(posedge mclock or negedge mreset) begin
        if (!mreset)   r_data <= 8'h00;
        else if (w_rd) r_data <= w_in_range ? image_mem[bus.Address[2:0]] : 8'h00;
    end

    assign bus.Data_o = r_data;
`else
    logic w_unused_rd;

    assign w_unused_rd = w_rd;
    assign bus.Data_o  = 8'h00;
`endif

    assign w_wrap = r_cnt == CNT_W'(SCAN_DIV - 1);

    // Row and Col register together so no two rows are ever lit at once.
    always_ff @(posedge mclock or negedge mreset) begin
        if (!mreset) begin
            r_cnt <= '0;
            r_idx <= 3'd0;
            r_row <= 8'h00;
            r_col <= 8'hFF;
        end else begin
            r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
            r_idx <= w_wrap ? r_idx + 3'd1 : r_idx;
            r_row <= 8'h01 << r_idx;
            r_col <= ~image_mem[r_idx];
        end
    end

    assign Row = r_row;
    assign Col = r_col;
endmodule

// File: tb/tb_dotmatrix_ctrl.sv
// tb_dotmatrix_ctrl: directed bench for dotmatrix_ctrl with SCAN_DIV=4.
module tb_dotmatrix_ctrl;
    logic       mclock;
    logic       mreset;
    logic [7:0] Row;
    logic [7:0] Col;
    logic [7:0] mem [0:7];
    int         n_cmp = 0;
    int         n_err = 0;

    dotmatrix_ctrl_if bus();

    dotmatrix_ctrl #(.SCAN_DIV(4), .CNT_W(16)) dut (
        .mclock (mclock),
        .mreset (mreset),
        .bus    (bus),
        .Row    (Row),
        .Col    (Col)
    );

    initial mclock = 1'b0;
    always #5 mclock = ~mclock;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge mclock);
        @(negedge mclock);
    endtask

    task automatic bus_write(input logic [7:0] addr, input logic [7:0] data);
        bus.CS = 1'b1; bus.Write = 1'b1; bus.Address = addr; bus.Data_i = data;
        check("wr_ack_pre", bus.ack, 1'b0);
        cycle();
        check("wr_ack_rise", bus.ack, 1'b1);
        bus.CS = 1'b0; bus.Write = 1'b0;
        cycle();
        check("wr_ack_fall", bus.ack, 1'b0);
        if (addr < 8) mem[addr[2:0]] = data;
    endtask

    task automatic bus_read(input logic [7:0] addr, input logic [7:0] exp);
        bus.CS = 1'b1; bus.Read = 1'b1; bus.Address = addr;
        cycle();
        check("rd_ack_rise", bus.ack, 1'b1);
        check("rd_data", bus.Data_o, exp);
        bus.CS = 1'b0; bus.Read = 1'b0;
        cycle();
        check("rd_ack_fall", bus.ack, 1'b0);
        check("rd_data_hold", bus.Data_o, exp);
    endtask

    // Reset realigns the scanner, then one full frame plus one row is checked.
    task automatic walk();
        mreset = 1'b0;
        #1;
        check("rst_ack", bus.ack, 1'b0);
        check("rst_data", bus.Data_o, 8'h00);
        check("rst_row", Row, 8'h00);
        check("rst_col", Col, 8'hFF);
        @(negedge mclock);
        mreset = 1'b1;
        for (int k = 0; k < 33; k++) begin
            cycle();
            check("scan_row", Row, 8'h01 << ((k / 4) % 8));
            check("scan_col", Col, ~mem[(k / 4) % 8]);
        end
    endtask

    initial begin
        mreset = 1'b0;
        bus.CS = 1'b0; bus.Write = 1'b0; bus.Read = 1'b0;
        bus.Address = 8'h00; bus.Data_i = 8'h00; bus.STRB = 4'hF;
        for (int i = 0; i < 8; i++) begin
            mem[i] = 8'(i + 1);
            dut.image_mem[i] <= 8'(i + 1);
        end
        @(negedge mclock);
        walk();
        for (int i = 0; i < 8; i++) bus_write(8'(i), 8'hFF - 8'(i));
        bus_write(8'd9, 8'h5A);
        walk();
`ifdef DOTMATRIX_READ_EN
        bus_write(8'd3, 8'hC3);
        bus_read(8'd3, 8'hC3);
        bus_read(8'd200, 8'h00);
`else
        bus_write(8'd3, 8'hC3);
        bus_read(8'd3, 8'h00);
`endif
        bus.Read = 1'b1; bus.Write = 1'b1; bus.CS = 1'b1; bus.Address = 8'd6; bus.Data_i = 8'h66;
        cycle();
        check("wr_rd_ack", bus.ack, 1'b1);
        check("wr_rd_data", bus.Data_o, 8'h00);
        bus.CS = 1'b0; bus.Read = 1'b0; bus.Write = 1'b0;
        mem[6] = 8'h66;
        cycle();
        bus.CS = 1'b1; bus.Write = 1'b1; bus.Address = 8'd5; bus.Data_i = 8'h11;
        cycle();
        check("mid_ack", bus.ack, 1'b1);
        mem[5] = 8'h11;
        mreset = 1'b0;
        #1;
        check("mid_rst_ack", bus.ack, 1'b0);
        check("mid_rst_row", Row, 8'h00);
        check("mid_rst_col", Col, 8'hFF);
        @(negedge mclock);
        mreset = 1'b1;
        cycle();
        check("post_rst_ack", bus.ack, 1'b1);
        bus.CS = 1'b0; bus.Write = 1'b0;
        cycle();
        check("post_rst_fall", bus.ack, 1'b0);
        bus.CS = 1'b1; bus.Address = 8'd0; bus.Data_i = 8'h42;
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("cs_only_ack", bus.ack, 1'b0);
        end
        bus.Write = 1'b1;
        cycle();
        check("cs_write_ack", bus.ack, 1'b1);
        mem[0] = 8'h42;
        bus.Data_i = 8'h99; bus.Address = 8'd1;
        cycle();
        check("acked_hold", bus.ack, 1'b1);
        bus.CS = 1'b0; bus.Write = 1'b0;
        cycle();
        check("acked_fall", bus.ack, 1'b0);
        walk();
        for (int i = 0; i < 8; i++) check("mem_final", dut.image_mem[i], mem[i]);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
